// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter.
// Optional build macro: PERIOD_METER_DEGLITCH_EN (adds a 3-sample glitch filter).
package period_meter_pkg;

   localparam int unsigned DEF_CNT_W       = 16;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StArm  = 2'd1,
      StMeas = 2'd2
   } state_e;

   // All-ones value for a counter of the given width (width below 64).
   function automatic logic [63:0] cnt_max(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer, optional glitch filter and history flop producing a one-cycle rise pulse.
// Optional build macro: PERIOD_METER_DEGLITCH_EN.
module sync_edge_det
   import period_meter_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PERIOD_METER_DEGLITCH_EN
   logic [1:0] dg_q, dg_d;
   logic       all_hi, all_lo;

   // Shift the synchronizer and filter; hist holds the filtered level and only
   // moves once three consecutive samples agree.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
      dg_d   = {dg_q[0], sync_out};
      all_hi = sync_out & dg_q[0] & dg_q[1];
      all_lo = ~(sync_out | dg_q[0] | dg_q[1]);
      hist_d = hist_q;
      if (all_hi) begin
         hist_d = 1'b1;
      end else if (all_lo) begin
         hist_d = 1'b0;
      end
      rise = all_hi & ~hist_q;
   end

   // Synchronizer, filter and history state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         dg_q   <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         dg_q   <= dg_d;
         hist_q <= hist_d;
      end
   end
`else
   // Shift the synchronizer; edge detect directly on the synchronized level.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_d = sync_out;
      rise   = sync_out & ~hist_q;
   end

   // Synchronizer and history state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end
`endif

endmodule

// File: rtl/period_meter.sv
// Measures the period of an asynchronous square wave in clk cycles and hands each
// result to a valid/ready consumer. Optional build macro: PERIOD_METER_DEGLITCH_EN.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic             per_valid,
   input  logic             per_ready,
   output logic [CNT_W-1:0] per_data,
   output logic             per_ovf,
   output logic             dropped
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] data_q, data_d;
   logic             ovf_q, ovf_d;
   logic             dropped_q, dropped_d;
   logic             rise;
   logic             capture;
   logic             accept;

   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge_det (
      .clk   (clk),
      .rst   (rst),
      .sig_in(sig_in),
      .rise  (rise)
   );

   // FSM and saturating period counter; the first edge only arms the measurement.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (en) begin
               state_d = StArm;
            end
         end
         StArm: begin
            if (rise) begin
               cnt_d   = CNT_W'(1);
               state_d = StMeas;
            end
         end
         StMeas: begin
            if (rise) begin
               capture = 1'b1;
               cnt_d   = CNT_W'(1);
            end else if (cnt_q != CntMax) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
      // Disabling discards any partial count.
      if (!en) begin
         state_d = StIdle;
         cnt_d   = '0;
         capture = 1'b0;
      end
      sat_d = (cnt_d == CntMax);
   end

   assign accept = valid_q & per_ready;

   // Single-entry result register: load if empty or being drained this cycle,
   // otherwise drop the new result and flag it.
   always_comb begin
      valid_d   = valid_q;
      data_d    = data_q;
      ovf_d     = ovf_q;
      dropped_d = dropped_q;
      if (capture) begin
         if (!valid_q || per_ready) begin
            valid_d = 1'b1;
            data_d  = sat_q ? CntMax : cnt_q;
            ovf_d   = sat_q;
         end else begin
            dropped_d = 1'b1;
         end
      end else if (accept) begin
         valid_d = 1'b0;
      end
      if (!en) begin
         valid_d   = 1'b0;
         data_d    = '0;
         ovf_d     = 1'b0;
         dropped_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         ovf_q     <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sat_q     <= sat_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         ovf_q     <= ovf_d;
         dropped_q <= dropped_d;
      end
   end

   assign per_valid = valid_q;
   assign per_data  = data_q;
   assign per_ovf   = ovf_q;
   assign dropped   = dropped_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a 16-bit and a 4-bit instance share the stimulus;
// expected periods are queued as edges are driven and checked at each handshake.
module tb_period_meter;

   typedef struct packed {
      logic [15:0] data;
      logic        ovf;
   } exp_t;

   logic        clk, rst, en, sig_in, per_ready;
   logic        per_valid, per_ovf, dropped;
   logic [15:0] per_data;
   logic        per_valid4, per_ovf4, dropped4;
   logic [3:0]  per_data4;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t q16[$];
   exp_t q4[$];
   bit   model_on, model_armed, valid_seen;
   int   last_rise, lat, d;

   period_meter #(
      .CNT_W      (16),
      .SYNC_STAGES(2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sig_in   (sig_in),
      .per_valid(per_valid),
      .per_ready(per_ready),
      .per_data (per_data),
      .per_ovf  (per_ovf),
      .dropped  (dropped)
   );

   period_meter #(
      .CNT_W      (4),
      .SYNC_STAGES(2)
   ) dut4 (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sig_in   (sig_in),
      .per_valid(per_valid4),
      .per_ready(per_ready),
      .per_data (per_data4),
      .per_ovf  (per_ovf4),
      .dropped  (dropped4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard side: every handshake pops one expected result per instance.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && per_valid) valid_seen = 1'b1;
      if (!rst && per_valid && per_ready) begin
         checks++;
         if (q16.size() == 0) begin
            assert (1'b0) else begin
               errors++;
               $error("FAIL result16_unexpected: got data=%0d ovf=%0b, expected no result",
                      per_data, per_ovf);
            end
         end else begin
            e = q16.pop_front();
            assert (per_data === e.data && per_ovf === e.ovf) else begin
               errors++;
               $error("FAIL result16: got data=%0d ovf=%0b, expected data=%0d ovf=%0b",
                      per_data, per_ovf, e.data, e.ovf);
            end
         end
      end
      if (!rst && per_valid4 && per_ready) begin
         checks++;
         if (q4.size() == 0) begin
            assert (1'b0) else begin
               errors++;
               $error("FAIL result4_unexpected: got data=%0d ovf=%0b, expected no result",
                      per_data4, per_ovf4);
            end
         end else begin
            e = q4.pop_front();
            assert ({12'd0, per_data4} === e.data && per_ovf4 === e.ovf) else begin
               errors++;
               $error("FAIL result4: got data=%0d ovf=%0b, expected data=%0d ovf=%0b",
                      per_data4, per_ovf4, e.data, e.ovf);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_exp(input int p);
      exp_t e16, e4;
      e16.data = (p >= 65535) ? 16'hffff : 16'(p);
      e16.ovf  = (p >= 65535);
      e4.data  = (p >= 15) ? 16'd15 : 16'(p);
      e4.ovf   = (p >= 15);
      q16.push_back(e16);
      q4.push_back(e4);
   endtask

   // Bench model: first edge after (re)enable arms, later edges close a period.
   task automatic note_rise();
      if (model_on && model_armed) push_exp(cyc - last_rise);
      last_rise   = cyc;
      model_armed = 1'b1;
   endtask

   task automatic drive_wave(input int n, input int hi, input int lo);
      for (int p = 0; p < n; p++) begin
         sig_in = 1'b1;
         note_rise();
         repeat (hi) step();
         sig_in = 1'b0;
         repeat (lo) step();
      end
   endtask

   task automatic check_clear(input string tag);
      chk({tag, "_valid"}, per_valid, 0);
      chk({tag, "_data"}, per_data, 0);
      chk({tag, "_ovf"}, per_ovf, 0);
      chk({tag, "_dropped"}, dropped, 0);
      chk({tag, "_valid4"}, per_valid4, 0);
      chk({tag, "_data4"}, per_data4, 0);
      chk({tag, "_ovf4"}, per_ovf4, 0);
      chk({tag, "_dropped4"}, dropped4, 0);
   endtask

   task automatic restart(input string tag);
      en = 1'b0;
      step();
      check_clear(tag);
      model_armed = 1'b0;
      en = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; sig_in = 1'b0; per_ready = 1'b1;
      model_on = 1'b1; model_armed = 1'b0; valid_seen = 1'b0;
      last_rise = 0; lat = 3; d = 0;
      repeat (3) step();
      check_clear("reset");
      rst = 1'b0;
      en  = 1'b1;
      repeat (4) step();

      // Period 16: arm, then time the first result, then steady results.
      drive_wave(1, 8, 8);
      sig_in = 1'b1;
      note_rise();
      d = cyc;
      for (int i = 0; i < 12 && per_valid !== 1'b1; i++) step();
      lat = cyc - d;
      chk("first_result_valid", per_valid, 1);
      if (lat < 8) repeat (8 - lat) step();
      sig_in = 1'b0;
      repeat (8) step();
      drive_wave(3, 8, 8);

      // Period 2.
      restart("en_off_meas");
`ifdef PERIOD_METER_DEGLITCH_EN
      model_on   = 1'b0;
      valid_seen = 1'b0;
      drive_wave(8, 1, 1);
      repeat (8) step();
      chk("deglitch_no_valid", valid_seen, 0);
      model_on = 1'b1;
`else
      drive_wave(8, 1, 1);
      repeat (8) step();
`endif

      // Period 20 saturates the 4-bit instance, then period 10 reads exactly.
      restart("restart_sat");
      drive_wave(3, 10, 10);
      drive_wave(3, 5, 5);

      // Consumer stalled over several periods of 12.
      restart("restart_drop");
      per_ready = 1'b0;
      model_on  = 1'b0;
      drive_wave(3, 6, 6);
      sig_in = 1'b1;
      note_rise();
      repeat (6) step();
      sig_in = 1'b0;
      repeat (5) step();
      chk("held_valid", per_valid, 1);
      chk("held_data", per_data, 12);
      chk("dropped_set", dropped, 1);
      chk("held_data4", per_data4, 12);
      chk("dropped_set4", dropped4, 1);
      push_exp(12);
      per_ready = 1'b1;
      step();
      chk("valid_fell", per_valid, 0);
      model_on = 1'b1;
      drive_wave(2, 6, 6);
      chk("dropped_sticky", dropped, 1);

      // Accept and capture in the same cycle.
      restart("restart_same");
      per_ready = 1'b0;
      model_on  = 1'b0;
      drive_wave(1, 5, 5);
      drive_wave(1, 7, 7);
      sig_in = 1'b1;
      note_rise();
      push_exp(10);
      push_exp(14);
      if (lat > 1 && lat < 7) repeat (lat - 1) step();
      per_ready = 1'b1;
      step();
      per_ready = 1'b0;
      chk("same_cycle_valid", per_valid, 1);
      chk("same_cycle_data", per_data, 14);
      chk("same_cycle_dropped", dropped, 0);
      chk("same_cycle_data4", per_data4, 14);
      per_ready = 1'b1;
      step();
      repeat (4) step();
      sig_in = 1'b0;
      repeat (7) step();
      model_on = 1'b1;

      // Reset mid-measurement, then re-arm and measure again.
      restart("restart_rst");
      drive_wave(2, 6, 6);
      rst = 1'b1;
      step();
      check_clear("rst_mid_meas");
      rst = 1'b0;
      model_armed = 1'b0;
      repeat (4) step();
      drive_wave(3, 8, 8);
      repeat (20) step();

      chk("queue16_drained", q16.size(), 0);
      chk("queue4_drained", q4.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
